// File: rtl/window_serializer.sv
// Captures the upstream FIFO's parallel window on request and streams the valid
// words out oldest first over a valid/ready handshake, tracking fill from write_en.
module window_serializer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write_en,
    input  logic [WIDTH*DEPTH-1:0]     win_in,
    input  logic                       snap_req,
    output logic                       busy,
    output logic                       snap_err,
    output logic [$clog2(DEPTH+1)-1:0] fill_cnt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_last,
    output logic [$clog2(DEPTH)-1:0]   out_idx
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state_q, state_d;
    logic [WIDTH*DEPTH-1:0] snap_q, snap_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          fill_q, fill_d;
    logic [CW-1:0]          sel;
    logic [IW-1:0]          idx_q, idx_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   last_q, last_d;
    logic                   err_q, err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            snap_q  <= '0;
            cnt_q   <= '0;
            fill_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // Output word is preselected one cycle ahead so out_data is purely registered.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        last_d  = last_q;
        err_d   = 1'b0;
        sel     = '0;
        fill_d  = (write_en && (fill_q != FULL)) ? fill_q + 1'b1 : fill_q;

        case (state_q)
            IDLE: begin
                if (snap_req) begin
                    if (fill_q != '0) begin
                        sel     = fill_q - 1'b1;
                        state_d = SEND;
                        snap_d  = win_in;
                        cnt_d   = fill_q;
                        idx_d   = '0;
                        data_d  = win_in[int'(sel)*WIDTH +: WIDTH];
                        last_d  = (fill_q == CW'(1));
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        data_d  = '0;
                        last_d  = 1'b0;
                    end else begin
                        // Next word index counts down from the oldest captured slot.
                        sel    = cnt_q - CW'(idx_q) - CW'(2);
                        idx_d  = idx_q + 1'b1;
                        data_d = snap_q[int'(sel)*WIDTH +: WIDTH];
                        last_d = ((CW'(idx_q) + CW'(2)) == cnt_q);
                    end
                end
            end
        endcase
    end

    assign busy      = (state_q == SEND);
    assign out_valid = (state_q == SEND);
    assign snap_err  = err_q;
    assign fill_cnt  = fill_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_idx   = idx_q;

endmodule

// File: tb/tb_window_serializer.sv
// Scoreboard bench: emulates the upstream shift window, predicts the stream from a
// write-history queue, and checks every cycle from a separate negedge monitor.
module tb_window_serializer;
    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct {
        logic [WIDTH-1:0] data;
        int               idx;
        bit               last;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic write_en = 1'b0;
    logic snap_req = 1'b0;
    logic out_ready = 1'b0;
    logic [WIDTH-1:0] wdata = '0;
    logic [WIDTH*DEPTH-1:0] win_in;
    logic busy, snap_err, out_valid, out_last;
    logic [CW-1:0] fill_cnt;
    logic [WIDTH-1:0] out_data;
    logic [IW-1:0] out_idx;

    logic [WIDTH-1:0] win_q [DEPTH];
    logic [WIDTH-1:0] hist [$];
    item_t exp_q [$];
    bit m_busy = 1'b0;
    bit m_err = 1'b0;
    int m_left = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    window_serializer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .write_en(write_en), .win_in(win_in),
        .snap_req(snap_req), .busy(busy), .snap_err(snap_err), .fill_cnt(fill_cnt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_idx(out_idx)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Upstream FIFO window: newest in word 0; unfilled slots hold random junk.
    always @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) win_q[k] <= WIDTH'($urandom);
        end else if (write_en) begin
            win_q[0] <= wdata;
            for (int k = 1; k < DEPTH; k++) win_q[k] <= win_q[k-1];
        end
    end

    always_comb begin
        win_in = '0;
        for (int k = 0; k < DEPTH; k++) win_in[k*WIDTH +: WIDTH] = win_q[k];
    end

    // Reference: a snapshot emits the retained writes in the order they were written.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0;
            m_err  <= 1'b0;
            m_left <= 0;
            hist.delete();
            exp_q.delete();
        end else begin
            m_err <= snap_req && !m_busy && (hist.size() == 0);
            if (snap_req && !m_busy && (hist.size() > 0)) begin
                for (int i = 0; i < hist.size(); i++)
                    exp_q.push_back('{data: hist[i], idx: i, last: (i == hist.size() - 1)});
                m_busy <= 1'b1;
                m_left <= hist.size();
            end else if (m_busy && out_ready) begin
                m_left <= m_left - 1;
                if (m_left == 1) m_busy <= 1'b0;
            end
            if (write_en) begin
                hist.push_back(wdata);
                if (hist.size() > DEPTH) void'(hist.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_busy);
        chk("out_valid", out_valid, m_busy);
        chk("fill_cnt", fill_cnt, hist.size());
        chk("snap_err", snap_err, m_err);
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", out_data, -1);
            end else begin
                chk("out_data", out_data, exp_q[0].data);
                chk("out_idx", out_idx, exp_q[0].idx);
                chk("out_last", out_last, exp_q[0].last);
                if (out_ready) void'(exp_q.pop_front());
            end
        end else begin
            chk("idle_data", out_data, 0);
            chk("idle_last", out_last, 0);
        end
    end

    task automatic step(input bit we, input logic [WIDTH-1:0] d, input bit sr, input bit rdy);
        write_en  = we;
        wdata     = d;
        snap_req  = sr;
        out_ready = rdy;
        @(posedge clk);
        #1;
        write_en = 1'b0;
        snap_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic fill_1_to_8();
        for (int v = 1; v <= 8; v++) step(1'b1, WIDTH'(v), 1'b0, 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_busy && n < 40) begin
            step(1'b0, '0, 1'b0, 1'b1);
            n++;
        end
        chk("drain_timeout", m_busy, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fill", fill_cnt, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_err", snap_err, 0);
        rst = 1'b1;

        step(1'b0, '0, 1'b1, 1'b1);
        chk("empty_err", snap_err, 1);
        chk("empty_valid", out_valid, 0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("empty_err_pulse", snap_err, 0);

        fill_1_to_8();
        step(1'b0, '0, 1'b1, 1'b1);
        chk("full_first", out_data, 5);
        wait_idle();

        do_reset();
        step(1'b1, 8'd1, 1'b0, 1'b1);
        step(1'b1, 8'd2, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("partial_first", out_data, 1);
        wait_idle();

        do_reset();
        fill_1_to_8();
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        chk("bp_data", out_data, 6);
        chk("bp_idx", out_idx, 1);
        chk("bp_valid", out_valid, 1);
        wait_idle();

        do_reset();
        fill_1_to_8();
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 8'hAA, 1'b1, 1'b1);
        step(1'b1, 8'hBB, 1'b1, 1'b0);
        chk("coll_fill", fill_cnt, 4);
        wait_idle();
        step(1'b0, '0, 1'b1, 1'b1);
        wait_idle();

        do_reset();
        fill_1_to_8();
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_fill", fill_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0, '0, 1'b1, 1'b1);
        chk("post_rst_err", snap_err, 1);

        do_reset();
        for (int i = 0; i < 3000; i++)
            step(1'(($urandom_range(0, 2) != 0)), WIDTH'($urandom),
                 1'(($urandom_range(0, 6) == 0)), 1'(($urandom_range(0, 3) != 0)));
        wait_idle();
        step(1'b0, '0, 1'b0, 1'b1);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/window_serializer.md
Name: window_serializer

Overview:
- Downstream consumer of the bypass FIFO's flattened parallel window (DEPTH words of WIDTH bits).
- Tracks how many valid words the window holds by monitoring the FIFO's write_en.
- On a snapshot request it latches the window and drains it one word per handshake, oldest first, over a valid/ready stream.
- It is the FIFO-to-serial-bus bridge.

Parameters:
- DEPTH, 4: words in the upstream window; must be >= 2.
- WIDTH, 8: bits per word.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- write_en  input  1  copy of the upstream FIFO write strobe; used only for fill tracking.
- win_in  input  WIDTH*DEPTH  flattened window. Word k is bits [k*WIDTH +: WIDTH]. Word 0 is the newest entry, word DEPTH-1 the oldest.
- snap_req  input  1  single-cycle request to capture and drain the window.
- busy  output  1  high while a snapshot is being drained.
- snap_err  output  1  one-cycle pulse when snap_req arrives with an empty window.
- fill_cnt  output  $clog2(DEPTH+1)  valid words in the upstream window; saturates at DEPTH.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accept.
- out_data  output  WIDTH  current output word.
- out_last  output  1  high with the final word of a snapshot.
- out_idx  output  $clog2(DEPTH)  index of the current word within the snapshot, starting at 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - fill_cnt=0, busy=0, snap_err=0, out_valid=0, out_last=0, out_idx=0, out_data=0.
  - FSM forced to IDLE, snapshot register cleared.
  - Applies immediately, including mid-drain; the partial snapshot is discarded and no further words are emitted.
- Fill tracking: each clk edge with write_en=1 increments fill_cnt, saturating at DEPTH.
- FSM has two states, IDLE and SEND.
- IDLE with snap_req=1 and fill_cnt=N>0:
  - Latch win_in into the snapshot register.
  - Latch N as the word count.
  - Go to SEND next cycle: busy=1, out_valid=1, out_idx=0.
- IDLE with snap_req=1 and fill_cnt=0: snap_err=1 for one cycle, stay IDLE, no output.
- snap_req coinciding with write_en:
  - Capture win_in and fill_cnt as presented that cycle, i.e. pre-write.
  - fill_cnt still increments.
- SEND emission order is oldest first:
  - Word at out_idx=i is snapshot word (N-1-i).
  - With N=DEPTH, the first word is word DEPTH-1.
  - With N<DEPTH, only words N-1 down to 0 are emitted; unfilled slots are never output.
- Handshake rules:
  - A transfer occurs on a clk edge with out_valid=1 and out_ready=1.
  - out_valid stays high, and out_data/out_idx/out_last stay stable, until the transfer completes.
  - No combinational path from out_ready to out_valid.
- out_last=1 exactly when out_idx=N-1.
- Transfer with out_last=1: next cycle out_valid=0, busy=0, out_last=0, out_idx=0, FSM back to IDLE.
  - The next snapshot can be accepted in that IDLE cycle, giving minimum 1 idle cycle between snapshots.
- snap_req while busy=1 is ignored: no error, no re-capture.
- write_en activity during SEND updates fill_cnt but never alters the latched snapshot.
- Latency: snap_req edge to first out_valid is 1 cycle. With out_ready held high, throughput is 1 word/cycle.
- out_data is registered and equals 0 whenever out_valid=0.

Test Plan:
- Full drain (DEPTH=4, WIDTH=8): write 1..8 on consecutive cycles, so win_in words 0..3 = 8,7,6,5 and fill_cnt=4. Pulse snap_req with out_ready=1 -> out_data 5,6,7,8 on 4 consecutive cycles, out_idx 0..3, out_last only with 8, then busy=0.
- Partial window: after reset write 1,2 (words 0,1 = 2,1, fill_cnt=2), snap_req -> emits 1 then 2, out_last with 2, exactly 2 transfers.
- Empty snap: snap_req right after reset -> snap_err pulses 1 cycle, out_valid stays 0, busy stays 0.
- Backpressure: full drain with out_ready low for 3 cycles on word 6 -> out_data=6, out_idx=1, out_valid=1 held stable, no skip or duplicate, sequence 5,6,7,8 intact.
- Busy collision: second snap_req and write_en=1 during SEND -> ignored, snapshot output unchanged, fill_cnt saturated at 4.
- Reset mid-drain: assert rst=0 after word 6 transfers -> out_valid, busy and fill_cnt go to 0 immediately (before the next edge). After release, snap_req yields snap_err.
